multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle combinational decoder. It accepts one instruction per valid/ready handshake and sequences it through DECODE, EXEC, MEM and WB states. In each state it drives the datapath control signals: register-file selects, ALU op, mux selects, memory cs/wr, and register-file write enable. It sits between the instruction fetch stage and the register file / ALU / data memory.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake and datapath-control bundle between fetch, multicycle_control and the
// register file / ALU / data memory. The slave modport is the controller's view.
interface multicycle_control_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      instr_valid;
   logic                      instr_ready;
   logic [DATA_WIDTH-1:0]     instruction;
   logic                      mem_ready;
   logic [REG_ADDR_WIDTH-1:0] rs;
   logic [REG_ADDR_WIDTH-1:0] rt;
   logic [REG_ADDR_WIDTH-1:0] rd;
   logic [2:0]                alu_control;
   logic                      ctl_mux_alu;
   logic                      ctl_mux_reg;
   logic                      cs;
   logic                      wr;
   logic                      erf;
   logic                      done;
   logic                      illegal;
   logic                      fault;

   modport master (
      output instr_valid, instruction, mem_ready,
      input  instr_ready, rs, rt, rd, alu_control, ctl_mux_alu, ctl_mux_reg,
             cs, wr, erf, done, illegal, fault
   );

   modport slave (
      input  instr_valid, instruction, mem_ready,
      output instr_ready, rs, rt, rd, alu_control, ctl_mux_alu, ctl_mux_reg,
             cs, wr, erf, done, illegal, fault
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer (IDLE/DECODE/EXEC/MEM/WB) driving registered datapath controls.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control #(
   parameter int         DATA_WIDTH     = 32,
   parameter int         REG_ADDR_WIDTH = 5,
   parameter logic [5:0] OP_RTYPE       = 6'b000100,
   parameter logic [5:0] OP_LW          = 6'b000101,
   parameter logic [5:0] OP_SW          = 6'b000110,
   parameter int         MEM_TIMEOUT    = 15
) (
   input logic                 clk,
   input logic                 rst,
   multicycle_control_if.slave bus
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]         retired_count
`endif
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t                state_r;
   logic [DATA_WIDTH-1:0] instr_r;
   logic [CNT_W-1:0]      wait_cnt_r;

   function automatic logic [5:0] opcode_of(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-1 -: 6];
   endfunction

   function automatic logic [REG_ADDR_WIDTH-1:0] rs_of(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-7 -: REG_ADDR_WIDTH];
   endfunction

   function automatic logic [REG_ADDR_WIDTH-1:0] rt_of(input logic [DATA_WIDTH-1:0] w);
      return w[DATA_WIDTH-7-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
   endfunction

   // Loads and stores write back to (or read from) the rt register.
   function automatic logic [REG_ADDR_WIDTH-1:0] rd_of(input logic [DATA_WIDTH-1:0] w);
      if (opcode_of(w) == OP_RTYPE) begin
         return w[15 -: REG_ADDR_WIDTH];
      end else begin
         return rt_of(w);
      end
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         6'd32:   return 3'd1;
         6'd34:   return 3'd2;
         6'd36:   return 3'd3;
         6'd37:   return 3'd4;
         6'd50:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic instr_legal(input logic [DATA_WIDTH-1:0] w);
      logic [5:0] op;
      op = opcode_of(w);
      return (op == OP_LW) || (op == OP_SW) ||
             ((op == OP_RTYPE) && (funct_alu(w[5:0]) != 3'd0));
   endfunction

   // Sequencer: state, latched instruction, MEM wait counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         instr_r         <= '0;
         wait_cnt_r      <= '0;
         bus.instr_ready <= 1'b1;
         bus.rs          <= '0;
         bus.rt          <= '0;
         bus.rd          <= '0;
         bus.alu_control <= 3'd0;
         bus.ctl_mux_alu <= 1'b0;
         bus.ctl_mux_reg <= 1'b0;
         bus.cs          <= 1'b0;
         bus.wr          <= 1'b0;
         bus.erf         <= 1'b0;
         bus.done        <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.fault       <= 1'b0;
      end else begin
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         bus.fault   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.instr_valid && bus.instr_ready) begin
                  state_r         <= DECODE;
                  instr_r         <= bus.instruction;
                  bus.instr_ready <= 1'b0;
                  bus.rs          <= rs_of(bus.instruction);
                  bus.rt          <= rt_of(bus.instruction);
                  bus.rd          <= rd_of(bus.instruction);
                  bus.illegal     <= ~instr_legal(bus.instruction);
               end else begin
                  bus.instr_ready <= 1'b1;
               end
            end
            DECODE: begin
               if (!instr_legal(instr_r)) begin
                  state_r         <= IDLE;
                  bus.instr_ready <= 1'b1;
                  bus.rs          <= '0;
                  bus.rt          <= '0;
                  bus.rd          <= '0;
               end else if (opcode_of(instr_r) == OP_RTYPE) begin
                  state_r         <= EXEC;
                  bus.alu_control <= funct_alu(instr_r[5:0]);
                  bus.ctl_mux_alu <= 1'b0;
                  bus.ctl_mux_reg <= 1'b0;
               end else begin
                  state_r         <= EXEC;
                  bus.alu_control <= 3'd1;
                  bus.ctl_mux_alu <= 1'b1;
                  bus.ctl_mux_reg <= 1'b1;
               end
            end
            EXEC: begin
               if (opcode_of(instr_r) == OP_RTYPE) begin
                  state_r  <= WB;
                  bus.erf  <= 1'b1;
                  bus.done <= 1'b1;
               end else begin
                  // A store whose memory is already ready retires in its first MEM cycle.
                  state_r    <= MEM;
                  wait_cnt_r <= CNT_W'(1);
                  bus.cs     <= 1'b1;
                  bus.wr     <= (opcode_of(instr_r) == OP_SW);
                  bus.done   <= (opcode_of(instr_r) == OP_SW) && bus.mem_ready;
               end
            end
            MEM: begin
               if (bus.done) begin
                  state_r         <= IDLE;
                  bus.instr_ready <= 1'b1;
                  bus.rs          <= '0;
                  bus.rt          <= '0;
                  bus.rd          <= '0;
                  bus.alu_control <= 3'd0;
                  bus.ctl_mux_alu <= 1'b0;
                  bus.ctl_mux_reg <= 1'b0;
                  bus.cs          <= 1'b0;
                  bus.wr          <= 1'b0;
               end else if (bus.mem_ready) begin
                  if (opcode_of(instr_r) == OP_SW) begin
                     bus.done <= 1'b1;
                  end else begin
                     state_r  <= WB;
                     bus.cs   <= 1'b0;
                     bus.wr   <= 1'b0;
                     bus.erf  <= 1'b1;
                     bus.done <= 1'b1;
                  end
               end else if ((MEM_TIMEOUT > 0) && (wait_cnt_r == CNT_W'(MEM_TIMEOUT))) begin
                  // Fault cycle sits in IDLE with instr_ready still low; ready rises next cycle.
                  state_r         <= IDLE;
                  bus.fault       <= 1'b1;
                  bus.rs          <= '0;
                  bus.rt          <= '0;
                  bus.rd          <= '0;
                  bus.alu_control <= 3'd0;
                  bus.ctl_mux_alu <= 1'b0;
                  bus.ctl_mux_reg <= 1'b0;
                  bus.cs          <= 1'b0;
                  bus.wr          <= 1'b0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            WB: begin
               state_r         <= IDLE;
               bus.instr_ready <= 1'b1;
               bus.rs          <= '0;
               bus.rt          <= '0;
               bus.rd          <= '0;
               bus.alu_control <= 3'd0;
               bus.ctl_mux_alu <= 1'b0;
               bus.ctl_mux_reg <= 1'b0;
               bus.erf         <= 1'b0;
            end
            default: begin
               state_r         <= IDLE;
               bus.instr_ready <= 1'b1;
               bus.rs          <= '0;
               bus.rt          <= '0;
               bus.rd          <= '0;
               bus.alu_control <= 3'd0;
               bus.ctl_mux_alu <= 1'b0;
               bus.ctl_mux_reg <= 1'b0;
               bus.cs          <= 1'b0;
               bus.wr          <= 1'b0;
               bus.erf         <= 1'b0;
            end
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   // Retired-instruction counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_count <= 32'd0;
      end else if (bus.done) begin
         retired_count <= retired_count + 32'd1;
      end else begin
         retired_count <= retired_count;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a timeline model predicts every output each cycle,
// and literal retirement/illegal/fault cycle numbers pin the model.
module tb_multicycle_control;

   localparam int T = 15;

   typedef struct packed {
      logic       ready;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [2:0] alu;
      logic       mux_alu;
      logic       mux_reg;
      logic       cs;
      logic       wr;
      logic       erf;
      logic       done;
      logic       illegal;
      logic       fault;
   } ov_t;

   logic clk;
   logic rst;
   multicycle_control_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_count;
`endif

   multicycle_control #(.MEM_TIMEOUT(T)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef CTRL_PERF_CNT_EN
      ,
      .retired_count(retired_count)
`endif
   );

   int  n_cmp = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  hs_cyc = 0;
   int  done_rel = -1;
   int  fault_rel = -1;
   int  ill_rel = -1;
   bit  check_en = 1'b0;
   ov_t exp_q[$];
   ov_t act;
   ov_t e_now;
   ov_t idle_ov;

   logic [5:0] functs [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd50};

   assign act = {bus.instr_ready, bus.rs, bus.rt, bus.rd, bus.alu_control, bus.ctl_mux_alu,
                 bus.ctl_mux_reg, bus.cs, bus.wr, bus.erf, bus.done, bus.illegal, bus.fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle comparison against the model timeline (idle when the timeline is exhausted).
   always @(negedge clk) begin
      if (check_en) begin
         if (exp_q.size() > 0) e_now = exp_q.pop_front();
         else e_now = idle_ov;
         n_cmp++;
         if (act !== e_now) begin
            n_fail++;
            $display("FAIL outputs cyc+%0d: got %h want %h", cyc - hs_cyc, act, e_now);
         end
         if (bus.done === 1'b1) done_rel = cyc - hs_cyc;
         if (bus.fault === 1'b1) fault_rel = cyc - hs_cyc;
         if (bus.illegal === 1'b1) ill_rel = cyc - hs_cyc;
      end
   end

   function automatic bit mr_at(input int mr_from, input int k);
      return (mr_from >= 0) && (k >= mr_from);
   endfunction

   task automatic check_int(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Expected outputs for cycles 1..n after the handshake, from the instruction and memory schedule.
   task automatic model_push(input logic [31:0] ins, input int mr_from, input int rst_at,
                             output int n);
      ov_t tl[$];
      ov_t v;
      logic [5:0] op;
      int alu;
      int hit;
      bit is_r, is_lw, is_sw, legal;
      op = ins[31:26];
      is_r  = (op == 6'b000100);
      is_lw = (op == 6'b000101);
      is_sw = (op == 6'b000110);
      alu = 0;
      for (int i = 0; i < 5; i++) if (ins[5:0] == functs[i]) alu = i + 1;
      legal = is_lw || is_sw || (is_r && alu != 0);
      v = '0;
      v.rs = ins[25:21];
      v.rt = ins[20:16];
      v.rd = is_r ? ins[15:11] : ins[20:16];
      v.illegal = !legal;
      tl.push_back(v);
      if (legal) begin
         v.illegal = 1'b0;
         v.alu     = is_r ? alu[2:0] : 3'd1;
         v.mux_alu = !is_r;
         v.mux_reg = !is_r;
         tl.push_back(v);
         if (is_r) begin
            v.erf = 1'b1; v.done = 1'b1;
            tl.push_back(v);
         end else begin
            hit = -1;
            for (int c = (is_sw ? 2 : 3); c <= 2 + T && hit < 0; c++)
               if (mr_at(mr_from, c)) hit = c;
            v.cs = 1'b1;
            v.wr = is_sw;
            if (hit < 0) begin
               for (int c = 3; c <= 2 + T; c++) tl.push_back(v);
               v = '0; v.fault = 1'b1;
               tl.push_back(v);
            end else if (is_lw) begin
               for (int c = 3; c <= hit; c++) tl.push_back(v);
               v.cs = 1'b0; v.erf = 1'b1; v.done = 1'b1;
               tl.push_back(v);
            end else begin
               for (int c = 3; c <= hit; c++) tl.push_back(v);
               v.done = 1'b1;
               tl.push_back(v);
            end
         end
      end
      if (rst_at > 0) while (tl.size() > rst_at) void'(tl.pop_back());
      n = tl.size();
      foreach (tl[i]) exp_q.push_back(tl[i]);
   endtask

   task automatic run_instr(input string name, input logic [31:0] ins, input int mr_from,
                            input int rst_at, input int want_done, input int want_ill,
                            input int want_fault);
      int n;
      @(posedge clk); #1;
      done_rel = -1; fault_rel = -1; ill_rel = -1;
      bus.instr_valid = 1'b1;
      bus.instruction = ins;
      bus.mem_ready   = mr_at(mr_from, 0);
      hs_cyc = cyc;
      @(posedge clk); #1;
      bus.instruction = $urandom;
      model_push(ins, mr_from, rst_at, n);
      for (int k = 1; k <= n; k++) begin
         bus.instr_valid = 1'($urandom_range(0, 1));
         bus.mem_ready   = mr_at(mr_from, k);
         if (k == rst_at) rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
      end
      bus.instr_valid = 1'b0;
      @(negedge clk); #1;
      check_int({name, " done_at"}, done_rel, want_done);
      check_int({name, " illegal_at"}, ill_rel, want_ill);
      check_int({name, " fault_at"}, fault_rel, want_fault);
      check_int({name, " ready_after"}, int'(bus.instr_ready), 1);
      check_int({name, " cs_after"}, int'(bus.cs), 0);
   endtask

   logic [31:0] rvec [5] = '{32'h10221820, 32'h10221822, 32'h10221824, 32'h10221825, 32'h10221832};

   initial begin
      idle_ov = '0;
      idle_ov.ready = 1'b1;
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instruction = 32'h0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      check_int("reset outputs", int'(act), int'(27'h4000000));
`ifdef CTRL_PERF_CNT_EN
      check_int("reset retired_count", int'(retired_count), 0);
`endif
      for (int i = 0; i < 5; i++) run_instr("rtype", rvec[i], -1, 0, 3, -1, -1);
      run_instr("lw_wait3",  32'h14850010, 6,  0, 7,  -1, -1);
      run_instr("lw_ready",  32'h14850010, 0,  0, 4,  -1, -1);
      run_instr("sw_ready",  32'h18860008, 0,  0, 3,  -1, -1);
      run_instr("sw_wait",   32'h18860008, 5,  0, 6,  -1, -1);
      run_instr("bad_op",    32'hFC000000, 0,  0, -1, 1,  -1);
      run_instr("bad_funct", 32'h1022183F, 0,  0, -1, 1,  -1);
      run_instr("lw_tmo",    32'h14850010, -1, 0, -1, -1, 18);
      run_instr("sw_tmo",    32'h18860008, -1, 0, -1, -1, 18);
      run_instr("lw_expiry", 32'h14850010, 17, 0, 18, -1, -1);
      run_instr("rst_mem",   32'h14850010, -1, 5, -1, -1, -1);
`ifdef CTRL_PERF_CNT_EN
      check_int("retired_count", int'(retired_count), 10);
`endif
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
